// File: rtl/step_ramp_ctrl.sv
// Trapezoidal speed-ramp sequencer feeding the step/PWM generator's half-period and enable.
module step_ramp_ctrl #(
    parameter int unsigned HP_W     = 20,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned HP_START = 50_000,
    parameter int unsigned HP_MIN   = 6_800,
    parameter int unsigned HP_STEP  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             abort,
    input  logic             pwm_fb,
    output logic [HP_W-1:0]  hp_out,
    output logic             gen_en,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    localparam int unsigned HPX_W = HP_W + 1;

    localparam logic [HPX_W-1:0] HPX_START   = HPX_W'(HP_START);
    localparam logic [HPX_W-1:0] HPX_STEP    = HPX_W'(HP_STEP);
    localparam logic [HPX_W-1:0] HPX_DEC_LIM = HPX_W'(HP_MIN + HP_STEP);
    localparam logic [HP_W-1:0]  HP_START_V  = HP_W'(HP_START);
    localparam logic [HP_W-1:0]  HP_MIN_V    = HP_W'(HP_MIN);
    localparam logic [HP_W-1:0]  HP_STEP_V   = HP_W'(HP_STEP);
    localparam logic [CNT_W-1:0] ACC_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_FINISH
    } state_t;

    state_t           state, state_nxt;
    logic [HP_W-1:0]  hp_nxt;
    logic             gen_en_nxt, dir_nxt, done_nxt, busy_nxt, ready_nxt;
    logic [CNT_W-1:0] sl_nxt;
    logic [CNT_W-1:0] acc, acc_nxt;
    logic             abort_flag, abort_flag_nxt;
    logic             fb_d, edge_q;

    logic [HPX_W-1:0] hp_x, hp_up;
    logic [HP_W-1:0]  hp_inc, hp_dec;
    logic             dec_sat;
    logic [CNT_W-1:0] sl_dec, sl_abort, acc_inc;
    logic             sl_last;

    // Saturating half-period arithmetic in one extra bit, clamped to [HP_MIN, HP_START]
    always_comb begin
        hp_x    = {1'b0, hp_out};
        hp_up   = hp_x + HPX_STEP;
        hp_inc  = (hp_up >= HPX_START) ? HP_START_V : hp_up[HP_W-1:0];
        dec_sat = (hp_x <= HPX_DEC_LIM);
        hp_dec  = dec_sat ? HP_MIN_V : (hp_out - HP_STEP_V);
    end

    // Step counter helpers: decrement never wraps, accel count saturates
    always_comb begin
        sl_dec   = (steps_left != '0) ? (steps_left - CNT_W'(1)) : '0;
        sl_last  = (sl_dec == '0);
        sl_abort = (sl_dec < acc) ? sl_dec : acc;
        acc_inc  = (acc == ACC_MAX) ? acc : (acc + CNT_W'(1));
    end

    // Feedback sync and rising-edge detect; the edge is registered so updates land two clocks after the rise
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_d   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            fb_d   <= pwm_fb;
            edge_q <= pwm_fb & ~fb_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hp_out     <= HP_START_V;
            gen_en     <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
            steps_left <= '0;
            acc        <= '0;
            abort_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            hp_out     <= hp_nxt;
            gen_en     <= gen_en_nxt;
            dir        <= dir_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            cmd_ready  <= ready_nxt;
            steps_left <= sl_nxt;
            acc        <= acc_nxt;
            abort_flag <= abort_flag_nxt;
        end
    end

    // Next-state and next-output logic; all ramp decisions are taken on a registered feedback edge
    always_comb begin
        state_nxt      = state;
        hp_nxt         = hp_out;
        gen_en_nxt     = gen_en;
        dir_nxt        = dir;
        done_nxt       = 1'b0;
        sl_nxt         = steps_left;
        acc_nxt        = acc;
        abort_flag_nxt = abort_flag;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    dir_nxt        = cmd_dir;
                    sl_nxt         = cmd_steps;
                    hp_nxt         = HP_START_V;
                    acc_nxt        = '0;
                    abort_flag_nxt = 1'b0;
                    if (cmd_steps == '0) begin
                        state_nxt  = S_FINISH;
                        gen_en_nxt = 1'b0;
                    end else begin
                        state_nxt  = S_ACCEL;
                        gen_en_nxt = 1'b1;
                    end
                end
            end

            S_ACCEL, S_CRUISE: begin
                if (abort) begin
                    abort_flag_nxt = 1'b1;
                end
                if (edge_q) begin
                    sl_nxt = sl_dec;
                    if (abort_flag) begin
                        // Controlled stop: only as many steps remain as were spent accelerating
                        sl_nxt         = sl_abort;
                        abort_flag_nxt = 1'b0;
                        if (sl_abort == '0) begin
                            state_nxt = S_FINISH;
                        end else begin
                            state_nxt = S_DECEL;
                            hp_nxt    = hp_inc;
                        end
                    end else if (sl_last) begin
                        state_nxt      = S_FINISH;
                        abort_flag_nxt = 1'b0;
                    end else if (sl_dec <= acc) begin
                        state_nxt      = S_DECEL;
                        hp_nxt         = hp_inc;
                        abort_flag_nxt = 1'b0;
                    end else if (state == S_ACCEL) begin
                        acc_nxt = acc_inc;
                        hp_nxt  = hp_dec;
                        if (dec_sat) begin
                            state_nxt = S_CRUISE;
                        end
                    end
                end
            end

            S_DECEL: begin
                if (edge_q) begin
                    sl_nxt = sl_dec;
                    if (sl_last) begin
                        state_nxt = S_FINISH;
                    end else begin
                        hp_nxt = hp_inc;
                    end
                end
            end

            S_FINISH: begin
                // Hold the generator until the last pulse has fallen
                if (!fb_d) begin
                    gen_en_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt  = (state_nxt != S_IDLE);
        ready_nxt = (state_nxt == S_IDLE);
    end

endmodule
